uartrx: RTL and testbench



---
 rtl/uartrx.sv | 245 ++++++++++++++++++++++++
 tb/tb_uartrx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uartrx.sv
// -----------------------------------------------------------------------------
// uartrx - receive-side UART, companion of uarttx.
//
// Frame: idle high, one start bit (0), 8 data bits LSB first, optional even
// parity bit, one stop bit (1). The serial line is synchronised by two flops
// and oversampled at 16x the baud rate. Each bit is sampled at its midpoint.
//
// Build option:
//   UARTRX_PARITY_EN - when defined, frames carry an even-parity bit between
//                      data bit 7 and the stop bit, and parity_err reports a
//                      mismatch. When undefined, there is no parity bit and
//                      parity_err is tied to 0. The port list is the same in
//                      both builds.
//
// Parameters:
//   clk_freq   system clock frequency in Hz
//   baud_rate  line bit rate; clk_freq/(baud_rate*16) must be >= 2
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx          asynchronous serial input, idle high
//   rx_data     last received byte, held until the next frame completes
//   donerx      one-cycle pulse when a frame completes
//   frame_err   stop bit of the last frame was 0 (valid with donerx, held)
//   parity_err  parity mismatch on the last frame (valid with donerx, held)
//   busy        high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uartrx #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       donerx,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  // Clocks per oversampling tick (16 ticks per bit).
  localparam int DIV   = clk_freq / (baud_rate * 16);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UARTRX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  // Synchroniser.
  logic r_rx_meta;
  logic r_rxs;

  // Oversampling tick generator.
  logic [CNT_W-1:0] r_div_cnt;
  logic             w_tick;
  logic             w_start_edge;

  // Receiver state.
  state_t     r_state;
  logic [3:0] r_sub;       // ticks within the current bit
  logic [2:0] r_idx;       // data bit being received
  logic [7:0] r_shift;     // byte under assembly
  logic [7:0] r_rx_data;
  logic       r_donerx;
  logic       r_frame_err;
  logic       r_busy;
`ifdef UARTRX_PARITY_EN
  logic       r_par_bit;
  logic       r_parity_err;
`endif

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. Both flops reset to the idle level so that leaving
  // reset never looks like a start edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the two flops a real 2-stage
      // pipeline; blocking ones would collapse it into a single flop.
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick generator. Restarted on the start edge so that tick n lands exactly
  // n*DIV clocks after the first low sample, which puts the start-bit sample
  // at its midpoint.
  // ---------------------------------------------------------------------------
  assign w_start_edge = (r_state == S_IDLE) && !r_rxs;
  assign w_tick       = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || w_start_edge) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM. Outputs are registered alongside the state so that rx_data,
  // the flags and donerx all change on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sub       <= 4'd0;
      r_idx       <= 3'd0;
      r_shift     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_donerx    <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UARTRX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      // donerx is a pulse: cleared every cycle unless STOP raises it below.
      r_donerx <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            r_sub   <= 4'd0;
            r_idx   <= 3'd0;
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        // Half a bit (8 ticks) into the start bit: a high line here means
        // the low level was a glitch, not a frame.
        S_START: begin
          if (w_tick) begin
            if (r_sub == 4'd7) begin
              r_sub <= 4'd0;
              if (r_rxs) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_DATA;
              end
            end else begin
              r_sub <= r_sub + 4'd1;
            end
          end
        end

        // The 4-bit sub counter wraps 15->0 on its own, so each full bit
        // period ends with the counter ready for the next bit.
        S_DATA: begin
          if (w_tick) begin
            r_sub <= r_sub + 4'd1;
            if (r_sub == 4'd15) begin
              r_shift[r_idx] <= r_rxs;
              r_idx          <= r_idx + 3'd1;
              if (r_idx == 3'd7) begin
`ifdef UARTRX_PARITY_EN
                r_state <= S_PARITY;
`else
                r_state <= S_STOP;
`endif
              end
            end
          end
        end

`ifdef UARTRX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_sub <= r_sub + 4'd1;
            if (r_sub == 4'd15) begin
              r_par_bit <= r_rxs;
              r_state   <= S_STOP;
            end
          end
        end
`endif

        S_STOP: begin
          if (w_tick) begin
            r_sub <= r_sub + 4'd1;
            if (r_sub == 4'd15) begin
              r_rx_data   <= r_shift;
              r_frame_err <= ~r_rxs;
              r_donerx    <= 1'b1;
`ifdef UARTRX_PARITY_EN
              // Even parity: data bits plus parity bit must XOR to 0.
              r_parity_err <= (^r_shift) ^ r_par_bit;
`endif
              if (r_rxs) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_BREAK;
              end
            end
          end
        end

        // A line held low after a bad stop bit must not be read as a stream
        // of 0x00 frames; wait for it to go high on a tick first.
        S_BREAK: begin
          if (w_tick && r_rxs) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign donerx    = r_donerx;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;
`ifdef UARTRX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uartrx.sv
// -----------------------------------------------------------------------------
// tb_uartrx - self-checking bench for uartrx.
//
// A sender task serialises bytes onto rx at the nominal bit period and pushes
// the expected result (byte, frame error, parity error, start cycle) onto a
// queue. A monitor pops the queue on every donerx pulse and compares. Works in
// both builds; the parity scenario runs only with UARTRX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uartrx;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);   // 10
  localparam int BIT_CLK  = 16 * DIV;                 // 160
`ifdef UARTRX_PARITY_EN
  localparam int N_AFTER_START = 10;
`else
  localparam int N_AFTER_START = 9;
`endif
  // rx fall -> donerx: 2 synchroniser clocks + stop-sample time + 1 output clk.
  localparam int LAT_NOM  = 2 + (8 + 16 * N_AFTER_START) * DIV + 1;
  localparam int MAX_CYC  = 90000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       donerx;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uartrx #(
    .clk_freq (CLK_FREQ),
    .baud_rate(BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .donerx    (donerx),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        ferr;
    logic        perr;
    int unsigned start;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_done = 0;
  logic        prev_done = 1'b0;
  logic [7:0]  model_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Cycle counter and run-away guard.
  always @(posedge clk) begin
    cyc++;
    if (cyc == MAX_CYC) begin
      $display("FAIL watchdog: got %0d cycles, expected fewer", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  // Monitor: every donerx pulse must match the oldest expected frame.
  always @(negedge clk) begin
    exp_t        e;
    int unsigned lat;
    if (donerx) begin
      n_done++;
      check("donerx_single_cycle", {31'd0, prev_done}, 32'd0);
      check("donerx_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        lat = cyc - e.start;
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        check("latency_window", {31'd0, (lat + 2 >= LAT_NOM) && (lat <= LAT_NOM + 2)}, 32'd1);
        model_data = e.data;
      end
    end
    prev_done = donerx;
  end

  // All stimulus tasks are entered and left on a falling clock edge.
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input bit expect_done);
    exp_t e;
    if (expect_done) begin
      e.data  = d;
      e.ferr  = ~stop;
`ifdef UARTRX_PARITY_EN
      e.perr  = (^d) ^ par;
`else
      e.perr  = 1'b0;
`endif
      e.start = cyc;
      exp_q.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UARTRX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
  endtask

  // Even parity bit that makes the frame correct.
  function automatic logic good_par(input logic [7:0] d);
    return ^d;
  endfunction

  initial begin
    int         n0;
    logic [7:0] d;
    logic [7:0] d96;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_donerx", {31'd0, donerx}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);

    // 1. Single frame 0xA5.
    n0 = n_done;
    send_frame(8'hA5, 1'b1, good_par(8'hA5), 1'b1);
    check("s1_done_count", n_done, n0 + 1);
    check("s1_busy_after", {31'd0, busy}, 32'd0);
    check("s1_rx_data_held", {24'd0, rx_data}, 32'h000000A5);

    // 2. 60-clk glitch is a false start.
    n0 = n_done;
    rx = 1'b0;
    repeat (30) @(negedge clk);
    check("s2_busy_during", {31'd0, busy}, 32'd1);
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("s2_busy_after", {31'd0, busy}, 32'd0);
    check("s2_no_done", n_done, n0);
    check("s2_rx_data_kept", {24'd0, rx_data}, {24'd0, model_data});

    // 3. Bad stop bit followed by a held-low line, then a good frame.
    n0 = n_done;
    send_frame(8'h3C, 1'b0, good_par(8'h3C), 1'b1);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    check("s3_one_done", n_done, n0 + 1);
    check("s3_busy_in_break", {31'd0, busy}, 32'd1);
    check("s3_frame_err_held", {31'd0, frame_err}, 32'd1);
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("s3_busy_after_break", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b1, good_par(8'h81), 1'b1);
    check("s3_second_done", n_done, n0 + 2);
    check("s3_frame_err_cleared", {31'd0, frame_err}, 32'd0);

    // 4. Back-to-back frames, no idle gap.
    n0 = n_done;
    send_frame(8'h00, 1'b1, good_par(8'h00), 1'b1);
    send_frame(8'hFF, 1'b1, good_par(8'hFF), 1'b1);
    send_frame(8'h55, 1'b1, good_par(8'h55), 1'b1);
    check("s4_three_done", n_done, n0 + 3);

    // 5. Reset in the middle of data bit 4 of 0x96, then 0x4B.
    n0  = n_done;
    d96 = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d96[i]);
    rx = d96[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s5_rx_data_reset", {24'd0, rx_data}, 32'd0);
    check("s5_donerx_reset", {31'd0, donerx}, 32'd0);
    check("s5_frame_err_reset", {31'd0, frame_err}, 32'd0);
    check("s5_parity_err_reset", {31'd0, parity_err}, 32'd0);
    check("s5_busy_reset", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("s5_no_done_for_aborted", n_done, n0);
    send_frame(8'h4B, 1'b1, good_par(8'h4B), 1'b1);
    check("s5_done_4b", n_done, n0 + 1);
    check("s5_rx_data_4b", {24'd0, rx_data}, 32'h0000004B);

`ifdef UARTRX_PARITY_EN
    // 6. Parity: 0x07 has three ones, so parity bit 1 is correct.
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check("s6_parity_ok", {31'd0, parity_err}, 32'd0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    check("s6_parity_bad", {31'd0, parity_err}, 32'd1);
    check("s6_rx_data", {24'd0, rx_data}, 32'h00000007);
`endif

    // Random frames with random idle gaps (and random parity bits).
    n0 = n_done;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    check("rand_done_count", n_done, n0 + 8);

    // Drain anything still in flight, bounded.
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    check("all_frames_received", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
